br_redirect_ctrl: RTL and testbench
===================================

BR_REDIRECT_CTRL -- requirements
Module: br_redirect_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of PC/target datapath.
REQ-002 Parameter FLUSH_CYCLES, default 2, number of cycles flush_o stays high after the redirect handshake (range 1..15).
REQ-003 clk_i  input  1  single core clock; all state on rising edge.
REQ-004 rstn_i  input  1  reset, asynchronous, active-low.
REQ-005 ex_valid_i  input  1  execute stage holds a valid instruction this cycle.
REQ-006 is_branch_i  input  1  instruction is a conditional branch (BEQ..BGEU).
REQ-007 is_jump_i  input  1  instruction is JAL/JALR.
REQ-008 branch_taken_i  input  1  branch decision from the branching unit.
REQ-009 brj_pc_i  input  DATA_WIDTH  target from the branching unit.
REQ-010 fetch_ready_i  input  1  fetch accepts a new PC this cycle.
REQ-011 redirect_valid_o  output  1  redirect request to fetch.
REQ-012 redirect_pc_o  output  DATA_WIDTH  latched target.
REQ-013 flush_o  output  1  kill IF/ID contents.
REQ-014 stall_ex_o  output  1  hold the execute stage.
REQ-015 misalign_o  output  1  one-cycle instruction-address-misaligned pulse.
REQ-016 branch_cnt_o / taken_cnt_o  output  32 each  resolved-branch and taken-branch counters.

Function
REQ-017 FSM states: IDLE, REDIRECT, FLUSH.
REQ-018 Event = ex_valid_i & (is_jump_i | (is_branch_i & branch_taken_i)); evaluated only in IDLE.
REQ-019 is_jump_i and is_branch_i both high: treated as jump; branch counters not updated.
REQ-020 IDLE + event + brj_pc_i[1:0]==2'b00: latch brj_pc_i into redirect_pc_o, go REDIRECT next edge.
REQ-021 IDLE + event + brj_pc_i[1]==1: misalign_o high for the next cycle only, no redirect, stay IDLE; brj_pc_i[0] is ignored (already cleared for JALR).
REQ-022 REDIRECT: redirect_valid_o=1, flush_o=1, stall_ex_o=1; redirect_pc_o stable until handshake.
REQ-023 Handshake = redirect_valid_o & fetch_ready_i; on handshake go FLUSH, load flush counter with FLUSH_CYCLES-1.
REQ-024 FLUSH: flush_o=1, stall_ex_o=1, redirect_valid_o=0; counter decrements each cycle; at 0 return IDLE next edge.
REQ-025 Redirect latency: redirect_valid_o high the cycle after the event; minimum event-to-IDLE = 1 + 1 + FLUSH_CYCLES cycles.
REQ-026 stall_ex_o = (state != IDLE); events while not IDLE are ignored and not counted.
REQ-027 branch_cnt_o increments on ex_valid_i & is_branch_i & ~is_jump_i in IDLE; taken_cnt_o additionally requires branch_taken_i; misaligned taken branches count as taken.
REQ-028 Counters wrap 0xFFFFFFFF -> 0 silently.
REQ-029 All outputs registered except stall_ex_o, which is decoded from state.

Reset
REQ-030 rstn_i low asynchronously forces IDLE, redirect_valid_o=0, flush_o=0, misalign_o=0, redirect_pc_o=0, counters=0, flush counter=0.
REQ-031 Reset mid-REDIRECT/FLUSH aborts the redirect; no handshake completes after release.
REQ-032 First event is accepted on the first rising edge after rstn_i deasserts.

Structure
REQ-033 FSM state encoding and the misalign cause code are placed in the shared defines header; DATA_WIDTH reuses the existing global width define.
REQ-034 A single sub-module br_evt_counter (32-bit enable counter with async reset) is instantiated twice; no other hierarchy.

Verification
REQ-035 BEQ taken, brj_pc_i=0x0000_0100, fetch_ready_i=1 -> redirect_valid_o one cycle with pc 0x100, flush_o 1+2 cycles, stall_ex_o 3 cycles, taken_cnt_o=1.
REQ-036 JAL target 0x200, fetch_ready_i low 4 cycles -> redirect_valid_o/redirect_pc_o stable 5 cycles, FLUSH entered only after ready, branch_cnt_o unchanged.
REQ-037 Taken branch target 0x0000_0102 -> misalign_o single pulse, no redirect_valid_o, stall_ex_o stays 0, taken_cnt_o=1.
REQ-038 Back-to-back events while in FLUSH -> ignored, counters unchanged, no second redirect.
REQ-039 rstn_i low during REDIRECT -> all outputs 0 immediately (async), FSM IDLE after release.
REQ-040 Preload-free wrap: 2^32 not-taken branches (forced counter value 0xFFFFFFFF) +1 -> branch_cnt_o=0.

Source files
------------

// File: rtl/br_redirect_ctrl_pkg.sv
// br_redirect_ctrl_pkg: shared width, FSM state encoding and misalign cause code for the redirect controller.
package br_redirect_ctrl_pkg;
    localparam int BR_DATA_WIDTH = 32;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REDIRECT = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [3:0] CAUSE_INSTR_MISALIGN = 4'd0;
endpackage

// File: rtl/br_evt_counter.sv
// br_evt_counter: 32-bit enable counter with async active-low reset; wraps silently.
module br_evt_counter (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        en_i,
    output logic [31:0] cnt_o
);
    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) cnt_o <= '0;
        else if (en_i) cnt_o <= cnt_o + 32'd1;
endmodule

// File: rtl/br_redirect_ctrl.sv
// br_redirect_ctrl: turns taken branches/jumps from execute into a fetch redirect plus a
// timed IF/ID flush, flags misaligned targets and counts resolved/taken branches.
module br_redirect_ctrl
    import br_redirect_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = BR_DATA_WIDTH,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  ex_valid_i,
    input  logic                  is_branch_i,
    input  logic                  is_jump_i,
    input  logic                  branch_taken_i,
    input  logic [DATA_WIDTH-1:0] brj_pc_i,
    input  logic                  fetch_ready_i,
    output logic                  redirect_valid_o,
    output logic [DATA_WIDTH-1:0] redirect_pc_o,
    output logic                  flush_o,
    output logic                  stall_ex_o,
    output logic                  misalign_o,
    output logic [31:0]           branch_cnt_o,
    output logic [31:0]           taken_cnt_o
);
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    logic [1:0] state;
    logic [3:0] flush_cnt;
    logic idle, evt, hs, br_en, tk_en;
    assign idle = state == ST_IDLE;
    assign evt = ex_valid_i & (is_jump_i | (is_branch_i & branch_taken_i));
    assign hs = redirect_valid_o & fetch_ready_i;
    // a simultaneous jump flag wins, so such an instruction is not a branch for counting
    assign br_en = idle & ex_valid_i & is_branch_i & ~is_jump_i;
    assign tk_en = br_en & branch_taken_i;
    assign stall_ex_o = ~idle;
    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) begin
            state <= ST_IDLE;
            flush_cnt <= '0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o <= '0;
            flush_o <= 1'b0;
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= 1'b0;
            if (idle) begin
                if (evt && brj_pc_i[1]) misalign_o <= 1'b1;
                else if (evt) begin
                    state <= ST_REDIRECT;
                    redirect_valid_o <= 1'b1;
                    flush_o <= 1'b1;
                    redirect_pc_o <= brj_pc_i;
                end
            end else if (state == ST_REDIRECT) begin
                if (hs) begin
                    state <= ST_FLUSH;
                    redirect_valid_o <= 1'b0;
                    flush_cnt <= FLUSH_LOAD;
                end
            end else if (flush_cnt == 4'd0) begin
                state <= ST_IDLE;
                flush_o <= 1'b0;
            end else flush_cnt <= flush_cnt - 4'd1;
        end
    br_evt_counter u_branch_cnt (.clk_i(clk_i), .rstn_i(rstn_i), .en_i(br_en), .cnt_o(branch_cnt_o));
    br_evt_counter u_taken_cnt (.clk_i(clk_i), .rstn_i(rstn_i), .en_i(tk_en), .cnt_o(taken_cnt_o));
endmodule

// File: tb/tb_br_redirect_ctrl.sv
// tb_br_redirect_ctrl: directed scenarios plus random traffic checked against a cycle-level reference model.
module tb_br_redirect_ctrl;
    localparam int FC = 2;
    logic clk = 1'b0;
    logic rstn_i = 1'b0;
    logic ex_valid_i = 1'b0, is_branch_i = 1'b0, is_jump_i = 1'b0, branch_taken_i = 1'b0, fetch_ready_i = 1'b0;
    logic [31:0] brj_pc_i = '0;
    logic redirect_valid_o, flush_o, stall_ex_o, misalign_o;
    logic [31:0] redirect_pc_o, branch_cnt_o, taken_cnt_o;
    int n_chk = 0, n_err = 0;
    bit m_redir, m_mis;
    int m_flush_left;
    logic [31:0] m_pc, m_bcnt, m_tcnt;

    always #5 clk = ~clk;

    br_redirect_ctrl #(.DATA_WIDTH(32), .FLUSH_CYCLES(FC)) dut (
        .clk_i(clk), .rstn_i(rstn_i), .ex_valid_i(ex_valid_i), .is_branch_i(is_branch_i),
        .is_jump_i(is_jump_i), .branch_taken_i(branch_taken_i), .brj_pc_i(brj_pc_i),
        .fetch_ready_i(fetch_ready_i), .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .flush_o(flush_o), .stall_ex_o(stall_ex_o), .misalign_o(misalign_o),
        .branch_cnt_o(branch_cnt_o), .taken_cnt_o(taken_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_redir = 0; m_mis = 0; m_flush_left = 0; m_pc = '0; m_bcnt = '0; m_tcnt = '0;
    endtask

    // one clock edge of the controller described as: busy = waiting for fetch or flushing
    task automatic model_edge();
        bit busy = m_redir || m_flush_left > 0;
        m_mis = 0;
        if (!busy) begin
            if (ex_valid_i && is_branch_i && !is_jump_i) begin
                m_bcnt++;
                if (branch_taken_i) m_tcnt++;
            end
            if (ex_valid_i && (is_jump_i || (is_branch_i && branch_taken_i))) begin
                if (brj_pc_i[1]) m_mis = 1;
                else begin
                    m_redir = 1;
                    m_pc = brj_pc_i;
                end
            end
        end else if (m_redir) begin
            if (fetch_ready_i) begin
                m_redir = 0;
                m_flush_left = FC;
            end
        end else m_flush_left--;
    endtask

    task automatic check_all(input string tag);
        bit busy = m_redir || m_flush_left > 0;
        chk({tag, ".valid"}, 64'(redirect_valid_o), 64'(m_redir));
        chk({tag, ".pc"}, 64'(redirect_pc_o), 64'(m_pc));
        chk({tag, ".flush"}, 64'(flush_o), 64'(busy));
        chk({tag, ".stall"}, 64'(stall_ex_o), 64'(busy));
        chk({tag, ".mis"}, 64'(misalign_o), 64'(m_mis));
        chk({tag, ".bcnt"}, 64'(branch_cnt_o), 64'(m_bcnt));
        chk({tag, ".tcnt"}, 64'(taken_cnt_o), 64'(m_tcnt));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic drive(input bit v, input bit br, input bit j, input bit tk, input logic [31:0] pc, input bit rdy);
        ex_valid_i = v; is_branch_i = br; is_jump_i = j; branch_taken_i = tk; brj_pc_i = pc; fetch_ready_i = rdy;
    endtask

    // called just after a negedge: async assert, check, release on the following negedge
    task automatic do_reset(input string tag);
        #2 rstn_i = 1'b0;
        #1 model_reset();
        check_all(tag);
        @(negedge clk);
        rstn_i = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        #1 check_all("rst");
        @(negedge clk);
        rstn_i = 1'b1;
        drive(1, 1, 0, 1, 32'h0000_0100, 1);
        step("beq_ev");
        drive(0, 0, 0, 0, 32'h0, 1);
        for (int i = 0; i < 4; i++) step("beq_tail");
        chk("beq_tcnt", 64'(taken_cnt_o), 64'd1);
        drive(1, 0, 1, 0, 32'h0000_0200, 0);
        step("jal_ev");
        drive(0, 0, 0, 0, 32'h0, 0);
        for (int i = 0; i < 4; i++) step("jal_wait");
        chk("jal_pc_held", 64'(redirect_pc_o), 64'h200);
        fetch_ready_i = 1;
        for (int i = 0; i < 4; i++) step("jal_tail");
        chk("jal_bcnt", 64'(branch_cnt_o), 64'd1);
        drive(1, 1, 0, 1, 32'h0000_0102, 1);
        step("mis_ev");
        drive(0, 0, 0, 0, 32'h0, 1);
        step("mis_after");
        chk("mis_tcnt", 64'(taken_cnt_o), 64'd2);
        drive(1, 1, 0, 1, 32'h0000_0300, 1);
        step("b2b_ev");
        drive(1, 1, 0, 1, 32'h0000_0400, 1);
        for (int i = 0; i < 3; i++) step("b2b_busy");
        drive(0, 0, 0, 0, 32'h0, 1);
        step("b2b_idle");
        chk("b2b_pc", 64'(redirect_pc_o), 64'h300);
        drive(1, 1, 1, 0, 32'h0000_0500, 0);
        step("both_ev");
        drive(0, 0, 0, 0, 32'h0, 0);
        step("both_hold");
        do_reset("rst_mid");
        drive(1, 0, 1, 0, 32'h0000_0600, 1);
        step("post_rst_ev");
        drive(0, 0, 0, 0, 32'h0, 1);
        for (int i = 0; i < 4; i++) step("post_rst_tail");
        force dut.u_branch_cnt.cnt_o = 32'hFFFF_FFFF;
        #1 release dut.u_branch_cnt.cnt_o;
        m_bcnt = 32'hFFFF_FFFF;
        chk("wrap_pre", 64'(branch_cnt_o), 64'hFFFF_FFFF);
        drive(1, 1, 0, 0, 32'h0000_0700, 1);
        step("wrap_ev");
        chk("wrap_zero", 64'(branch_cnt_o), 64'd0);
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] pc = $urandom;
            if ($urandom_range(3) != 0) pc[1] = 1'b0;
            drive($urandom_range(9) < 7, $urandom_range(1), $urandom_range(4) == 0,
                  $urandom_range(1), pc, $urandom_range(1));
            step("rnd");
            if ($urandom_range(299) == 0) do_reset("rnd_rst");
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
